// File: rtl/ex_branch.sv
// ex_branch: two-stage branch resolver that feeds a small in-order redirect FIFO toward fetch.
// Defining EX_BRANCH_STATS_EN adds the stat_total/stat_taken resolution counters and their ports.

`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef BEQ
`define BEQ  6'h18
`endif
`ifndef BNE
`define BNE  6'h19
`endif
`ifndef BLT
`define BLT  6'h1A
`endif
`ifndef BGE
`define BGE  6'h1B
`endif
`ifndef BLTU
`define BLTU 6'h1C
`endif
`ifndef BGEU
`define BGEU 6'h1D
`endif

module ex_branch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_branch_en,
    input  logic [`dataWidth-1:0]  exsrc1,
    input  logic [`dataWidth-1:0]  exsrc2,
    input  logic [`addrWidth-1:0]  expc,
    input  logic [`newopWidth-1:0] exaluop,
    input  logic [`dataWidth-1:0]  exoffset,
    output logic                   redirect_valid,
    input  logic                   redirect_ready,
    output logic [`addrWidth-1:0]  redirect_pc,
    output logic                   redirect_taken,
`ifdef EX_BRANCH_STATS_EN
    output logic [31:0]            stat_total,
    output logic [31:0]            stat_taken,
`endif
    output logic                   overflow,
    output logic                   bad_op
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                  taken;
        logic [`addrWidth-1:0] pc;
    } entry_t;

    // ---------------- stage 1: issue register ----------------
    logic                   s1_valid_q;
    logic [`dataWidth-1:0]  s1_src1_q;
    logic [`dataWidth-1:0]  s1_src2_q;
    logic [`addrWidth-1:0]  s1_pc_q;
    logic [`newopWidth-1:0] s1_op_q;
    logic [`dataWidth-1:0]  s1_off_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= ex_branch_en;
        end
    end

    // NOTE: payload and FIFO storage are not reset; the valid bit and occupancy count gate every use of them.
    always_ff @(posedge clk) begin
        if (ex_branch_en) begin
            s1_src1_q <= exsrc1;
            s1_src2_q <= exsrc2;
            s1_pc_q   <= expc;
            s1_op_q   <= exaluop;
            s1_off_q  <= exoffset;
        end
    end

    // ---------------- stage 2: resolve ----------------
    logic                  cmp_eq;
    logic                  cmp_lt_s;
    logic                  cmp_lt_u;
    logic                  res_taken;
    logic                  res_known;
    logic [`addrWidth-1:0] target_taken;
    logic [`addrWidth-1:0] target_seq;
    entry_t                res_entry;

    assign cmp_eq   = (s1_src1_q == s1_src2_q);
    assign cmp_lt_s = ($signed(s1_src1_q) < $signed(s1_src2_q));
    assign cmp_lt_u = (s1_src1_q < s1_src2_q);

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        res_taken = 1'b0;
        res_known = 1'b1;
        case (s1_op_q)
            `BEQ:    res_taken = cmp_eq;
            `BNE:    res_taken = !cmp_eq;
            `BLT:    res_taken = cmp_lt_s;
            `BGE:    res_taken = !cmp_lt_s;
            `BLTU:   res_taken = cmp_lt_u;
            `BGEU:   res_taken = !cmp_lt_u;
            default: res_known = 1'b0;
        endcase
    end

    // Both targets wrap naturally at the address width.
    assign target_taken    = s1_pc_q + s1_off_q[`addrWidth-1:0];
    assign target_seq      = s1_pc_q + `addrWidth'(4);
    assign res_entry.taken = res_taken;
    assign res_entry.pc    = res_taken ? target_taken : target_seq;

    // ---------------- redirect FIFO ----------------
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             overflow_q;
    logic             overflow_d;
    logic             bad_op_q;
    logic             bad_op_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = !fifo_empty && redirect_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the new entry.
    assign push       = s1_valid_q && (!fifo_full || pop);
    assign drop       = s1_valid_q && fifo_full && !pop;

    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q || drop;
        bad_op_d   = bad_op_q || (s1_valid_q && !res_known);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            bad_op_q   <= bad_op_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= res_entry;
        end
    end

    // Outputs are forced to zero while empty, which also covers the reset window.
    assign redirect_valid = !fifo_empty;
    assign redirect_pc    = fifo_empty ? '0   : fifo_mem[rd_ptr_q].pc;
    assign redirect_taken = fifo_empty ? 1'b0 : fifo_mem[rd_ptr_q].taken;
    assign overflow       = overflow_q;
    assign bad_op         = bad_op_q;

`ifdef EX_BRANCH_STATS_EN
    logic [31:0] stat_total_q;
    logic [31:0] stat_total_d;
    logic [31:0] stat_taken_q;
    logic [31:0] stat_taken_d;

    // Every resolution counts, whether it was pushed or dropped.
    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        if (s1_valid_q) begin
            stat_total_d = stat_total_q + 32'd1;
            if (res_taken) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_ex_branch.sv
// Randomized self-checking bench for ex_branch against a queue-based reference model.
// Builds with or without EX_BRANCH_STATS_EN; the counter checks follow the macro.

`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef BEQ
`define BEQ  6'h18
`endif
`ifndef BNE
`define BNE  6'h19
`endif
`ifndef BLT
`define BLT  6'h1A
`endif
`ifndef BGE
`define BGE  6'h1B
`endif
`ifndef BLTU
`define BLTU 6'h1C
`endif
`ifndef BGEU
`define BGEU 6'h1D
`endif

module tb_ex_branch;

    localparam int DEPTH = 2;
    localparam logic [5:0] OP_BAD = 6'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_branch_en;
    logic [31:0] exsrc1;
    logic [31:0] exsrc2;
    logic [31:0] expc;
    logic [5:0]  exaluop;
    logic [31:0] exoffset;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        redirect_taken;
    logic        overflow;
    logic        bad_op;
`ifdef EX_BRANCH_STATS_EN
    logic [31:0] stat_total;
    logic [31:0] stat_taken;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: FIFO as a queue of {taken, pc}, plus the one-cycle resolve delay.
    logic [32:0] mq[$];
    logic        m_s1_v;
    logic        m_s1_t;
    logic        m_s1_unk;
    logic [31:0] m_s1_pc;
    logic        m_ovf;
    logic        m_bad;
    longint      m_stot;
    longint      m_stak;

    ex_branch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_branch_en   (ex_branch_en),
        .exsrc1         (exsrc1),
        .exsrc2         (exsrc2),
        .expc           (expc),
        .exaluop        (exaluop),
        .exoffset       (exoffset),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .redirect_taken (redirect_taken),
`ifdef EX_BRANCH_STATS_EN
        .stat_total     (stat_total),
        .stat_taken     (stat_taken),
`endif
        .overflow       (overflow),
        .bad_op         (bad_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch semantics from first principles: 64-bit arithmetic, then reduce modulo 2^32.
    function automatic void model_resolve(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc, input logic [31:0] off,
                                          output logic taken, output logic [31:0] npc, output logic unk);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint sum;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = longint'({32'd0, a});
        ub    = longint'({32'd0, b});
        unk   = 1'b0;
        taken = 1'b0;
        if (op == `BEQ)       taken = (ua == ub);
        else if (op == `BNE)  taken = (ua != ub);
        else if (op == `BLT)  taken = (sa < sb);
        else if (op == `BGE)  taken = (sa >= sb);
        else if (op == `BLTU) taken = (ua < ub);
        else if (op == `BGEU) taken = (ua >= ub);
        else                  unk   = 1'b1;
        if (taken) sum = longint'({32'd0, pc}) + longint'($signed(off));
        else       sum = longint'({32'd0, pc}) + 64'sd4;
        npc = 32'(sum & 64'hFFFF_FFFF);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_s1_v = 1'b0;
        m_ovf  = 1'b0;
        m_bad  = 1'b0;
        m_stot = 0;
        m_stak = 0;
    endtask

    task automatic model_edge(input logic en, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] off, input logic rdy);
        logic        t;
        logic        u;
        logic [31:0] npc;
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (m_s1_v) begin
            m_stot = (m_stot + 1) % 64'h1_0000_0000;
            if (m_s1_t) m_stak = (m_stak + 1) % 64'h1_0000_0000;
            if (m_s1_unk) m_bad = 1'b1;
            if (mq.size() < DEPTH) mq.push_back({m_s1_t, m_s1_pc});
            else                   m_ovf = 1'b1;
        end
        m_s1_v = en;
        if (en) begin
            model_resolve(op, a, b, pc, off, t, npc, u);
            m_s1_t   = t;
            m_s1_pc  = npc;
            m_s1_unk = u;
        end
    endtask

    task automatic check_outputs();
        check("valid", {63'd0, redirect_valid}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("head_pc", {32'd0, redirect_pc}, {32'd0, mq[0][31:0]});
            check("head_taken", {63'd0, redirect_taken}, {63'd0, mq[0][32]});
        end
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check("bad_op", {63'd0, bad_op}, {63'd0, m_bad});
`ifdef EX_BRANCH_STATS_EN
        check("stat_total", {32'd0, stat_total}, 64'(m_stot));
        check("stat_taken", {32'd0, stat_taken}, 64'(m_stak));
`endif
    endtask

    // Called at a negedge: drive, let the rising edge happen, update the model, compare at the next negedge.
    task automatic cycle(input logic en, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off, input logic rdy);
        ex_branch_en   = en;
        exaluop        = op;
        exsrc1         = a;
        exsrc2         = b;
        expc           = pc;
        exoffset       = off;
        redirect_ready = rdy;
        @(posedge clk);
        model_edge(en, op, a, b, pc, off, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, `BEQ, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    // Asynchronous reset: outputs must clear within the same cycle, without waiting for an edge.
    task automatic do_reset();
        ex_branch_en   = 1'b0;
        redirect_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_valid", {63'd0, redirect_valid}, 64'd0);
        check("rst_pc", {32'd0, redirect_pc}, 64'd0);
        check("rst_taken", {63'd0, redirect_taken}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_bad_op", {63'd0, bad_op}, 64'd0);
`ifdef EX_BRANCH_STATS_EN
        check("rst_stat_total", {32'd0, stat_total}, 64'd0);
        check("rst_stat_taken", {32'd0, stat_taken}, 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] off;
        int          rdy_pct;

        ops[0] = `BEQ;  ops[1] = `BNE;  ops[2] = `BLT;
        ops[3] = `BGE;  ops[4] = `BLTU; ops[5] = `BGEU;

        rst = 1'b1;
        ex_branch_en = 1'b0; exsrc1 = '0; exsrc2 = '0; expc = '0;
        exaluop = '0; exoffset = '0; redirect_ready = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Equal BEQ: visible one edge after the issue edge, taken to pc+off.
        cycle(1'b1, `BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        check("beq_not_yet", {63'd0, redirect_valid}, 64'd0);
        idle(1'b1);
        check("beq_pc", {32'd0, redirect_pc}, 64'h120);
        check("beq_taken", {63'd0, redirect_taken}, 64'd1);
        idle(1'b1);

        // Signed versus unsigned compare on the same operands.
        cycle(1'b1, `BLT,  32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
        cycle(1'b1, `BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1);
        check("blt_pc", {32'd0, redirect_pc}, 64'h240);
        check("blt_taken", {63'd0, redirect_taken}, 64'd1);
        idle(1'b1);
        check("bltu_pc", {32'd0, redirect_pc}, 64'h304);
        check("bltu_taken", {63'd0, redirect_taken}, 64'd0);
        idle(1'b1);

        // Sequential target wraps past the top of the address space; then an unknown opcode.
        cycle(1'b1, `BEQ, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10, 1'b1);
        cycle(1'b1, OP_BAD, 32'd3, 32'd3, 32'h500, 32'h80, 1'b1);
        check("wrap_pc", {32'd0, redirect_pc}, 64'h0);
        check("wrap_valid", {63'd0, redirect_valid}, 64'd1);
        idle(1'b1);
        check("badop_pc", {32'd0, redirect_pc}, 64'h504);
        check("badop_taken", {63'd0, redirect_taken}, 64'd0);
        check("badop_flag", {63'd0, bad_op}, 64'd1);
        idle(1'b1);
        do_reset();

        // Three issues into a depth-2 FIFO with fetch stalled: the third is dropped.
        cycle(1'b1, `BEQ, 32'd7, 32'd7, 32'h1000, 32'h8, 1'b0);
        cycle(1'b1, `BEQ, 32'd7, 32'd7, 32'h2000, 32'h8, 1'b0);
        cycle(1'b1, `BEQ, 32'd7, 32'd7, 32'h3000, 32'h8, 1'b0);
        idle(1'b0);
        check("ovf_set", {63'd0, overflow}, 64'd1);
        check("ovf_head0", {32'd0, redirect_pc}, 64'h1008);
        idle(1'b1);
        check("ovf_head1", {32'd0, redirect_pc}, 64'h2008);
        idle(1'b1);
        check("ovf_drained", {63'd0, redirect_valid}, 64'd0);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        idle(1'b1);
        do_reset();

        // Full FIFO with a pop and a push on the same edge keeps everything, no overflow.
        cycle(1'b1, `BNE, 32'd1, 32'd2, 32'h4000, 32'h100, 1'b0);
        cycle(1'b1, `BNE, 32'd1, 32'd2, 32'h5000, 32'h100, 1'b0);
        cycle(1'b1, `BNE, 32'd1, 32'd2, 32'h6000, 32'h100, 1'b0);
        idle(1'b1);
        check("full_pp_ovf", {63'd0, overflow}, 64'd0);
        check("full_pp_head", {32'd0, redirect_pc}, 64'h5100);
        idle(1'b1);
        check("full_pp_tail", {32'd0, redirect_pc}, 64'h6100);
        idle(1'b1);

        // Reset with two entries queued: nothing stale may appear afterwards.
        cycle(1'b1, `BGE, 32'd9, 32'd2, 32'h7000, 32'h4, 1'b0);
        cycle(1'b1, `BGE, 32'd9, 32'd2, 32'h8000, 32'h4, 1'b0);
        idle(1'b0);
        check("pre_rst_valid", {63'd0, redirect_valid}, 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("post_rst_valid", {63'd0, redirect_valid}, 64'd0);

        // Randomized traffic in phases with different fetch acceptance rates.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) rdy_pct = $urandom_range(10, 100);
            if (i == 350) do_reset();
            op = ($urandom_range(0, 19) == 0) ? OP_BAD : ops[$urandom_range(0, 5)];
            a  = pick_val();
            b  = ($urandom_range(0, 3) == 0) ? a : pick_val();
            off = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed($urandom_range(0, 511)) - 256);
            cycle($urandom_range(0, 99) < 70, op, a, b, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom(),
                  off, $urandom_range(1, 100) <= rdy_pct);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_branch.md
EX_BRANCH -- requirements
Module: ex_branch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of resolved-branch entries buffered toward fetch (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ex_branch_en, input, 1 bit: an issued branch is present this cycle.
REQ-005 SHALL have ports exsrc1 and exsrc2, input, `dataWidth each: the compare operands.
REQ-006 SHALL have port expc, input, `addrWidth: the branch instruction PC.
REQ-007 SHALL have port exaluop, input, `newopWidth: the branch opcode (`BEQ, `BNE, `BLT, `BGE, `BLTU, `BGEU).
REQ-008 SHALL have port exoffset, input, `dataWidth: the sign-extended byte offset.
REQ-009 SHALL have port redirect_valid, output, 1 bit: the FIFO head holds a resolved branch.
REQ-010 SHALL have port redirect_ready, input, 1 bit: fetch accepts the head entry.
REQ-011 SHALL have port redirect_pc, output, `addrWidth: the resolved next PC of the head entry.
REQ-012 SHALL have port redirect_taken, output, 1 bit: the head entry's branch was taken.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a resolved branch was dropped.
REQ-014 SHALL have port bad_op, output, 1 bit: sticky flag, an unknown opcode was resolved.

Function
REQ-015 SHALL accept an issue in every cycle with ex_branch_en=1; there is no backpressure toward the reservation station.
REQ-016 SHALL register the inputs in stage 1 and resolve the branch in stage 2, so an issue at edge N is pushed into the FIFO at edge N+1.
REQ-017 SHALL evaluate the compare as follows: BEQ/BNE are equality; BLT/BGE are signed; BLTU/BGEU are unsigned.
REQ-018 SHALL compute the taken target as expc+exoffset modulo 2^`addrWidth, and the not-taken target as expc+4, wrapping.
REQ-019 SHALL resolve an unknown opcode as not-taken (expc+4) and set bad_op.
REQ-020 SHALL drive redirect_valid when the FIFO is non-empty, with redirect_pc and redirect_taken taken from the head entry.
REQ-021 SHALL pop the FIFO on each cycle with redirect_valid && redirect_ready.
REQ-022 SHALL not pop, and SHALL leave state unchanged, on redirect_ready while the FIFO is empty.
REQ-023 SHALL, on a simultaneous push and pop, pop the head and append the new entry, including when the FIFO is full (occupancy unchanged).
REQ-024 SHALL, on a push into a full FIFO with no pop, drop the new entry, leave FIFO contents unchanged, and set overflow.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and keep an occupancy count in the range 0..FIFO_DEPTH.
REQ-026 SHALL deliver entries to fetch in issue order.

Reset
REQ-027 SHALL, on rst=1 (asynchronous, active-high), immediately clear the stage-1 valid bit, the FIFO pointers and the occupancy count.
REQ-028 SHALL hold redirect_valid=0, redirect_pc=0, redirect_taken=0, overflow=0 and bad_op=0 while rst=1.
REQ-029 SHALL discard any in-flight stage-1 entry and all FIFO contents when rst asserts mid-operation.
REQ-030 SHALL never produce a redirect_valid pulse caused by pre-reset state after reset is released.

Configuration
REQ-031 SHALL, with macro EX_BRANCH_STATS_EN defined, add two output ports: stat_total and stat_taken, each 32 bits.
REQ-032 SHALL, with EX_BRANCH_STATS_EN defined, increment stat_total once per pushed-or-dropped resolution and stat_taken once per taken resolution; both wrap 0xFFFFFFFF->0 and are cleared by rst.
REQ-033 SHALL, without EX_BRANCH_STATS_EN, include neither the counters nor their ports, with all other behaviour identical.

Verification
REQ-034 Scenario: issue BEQ with src1=src2=5, pc=0x100, off=0x20, ready=1 -> redirect_valid at N+1 with pc=0x120, taken=1.
REQ-035 Scenario: issue BLT with src1=0xFFFFFFFF, src2=1 -> taken; issue BLTU with the same operands -> not taken, pc=expc+4.
REQ-036 Scenario: hold ready=0 and issue 3 branches back-to-back (depth 2) -> first two are held in order, third is dropped, overflow=1 and stays 1.
REQ-037 Scenario: FIFO full, ready=1 and a new issue on the same cycle -> head pops, new entry is appended, overflow stays 0.
REQ-038 Scenario: pc=0xFFFFFFFC, not-taken -> redirect_pc=0x00000000; an unknown op -> not-taken and bad_op=1.
REQ-039 Scenario: assert rst with 2 entries queued -> redirect_valid=0 immediately, and no stale output after release; with EX_BRANCH_STATS_EN, counters read 0.
